// File: rtl/xb_read32_packer_if.sv
// Handshake bundle between the acquisition source, the 16->32 packer and the
// Xillybus user_r_read_32 port of xillybus_core.
interface xb_read32_packer_if;
  logic [15:0] src_data;
  logic        src_valid;
  logic        src_last;
  logic        src_ready;
  logic        user_r_read_32_open;
  logic        user_r_read_32_rden;
  logic [31:0] user_r_read_32_data;
  logic        user_r_read_32_empty;
  logic        user_r_read_32_eof;

  // Master drives samples and the core's read controls; slave is the packer.
  modport master (
    output src_data, src_valid, src_last, user_r_read_32_open, user_r_read_32_rden,
    input  src_ready, user_r_read_32_data, user_r_read_32_empty, user_r_read_32_eof
  );

  modport slave (
    input  src_data, src_valid, src_last, user_r_read_32_open, user_r_read_32_rden,
    output src_ready, user_r_read_32_data, user_r_read_32_empty, user_r_read_32_eof
  );
endinterface

// File: rtl/xb_read32_packer.sv
// Packs 16-bit samples into 32-bit words, buffers them in a single-clock FIFO
// and feeds the Xillybus read_32 port. XB_READ32_LEVEL_EN adds the fifo_level output.
module xb_read32_packer #(
  parameter int DEPTH_LOG2 = 9
) (
  input  logic                  bus_clk,
  input  logic                  bus_rst,
  xb_read32_packer_if.slave     bus
`ifdef XB_READ32_LEVEL_EN
  ,
  output logic [DEPTH_LOG2:0]   fifo_level
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [DEPTH_LOG2:0]   cnt_t;

  localparam cnt_t CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam cnt_t CNT_ONE  = cnt_t'(1);
  localparam ptr_t PTR_ONE  = ptr_t'(1);

  logic [31:0] r_mem [DEPTH];
  ptr_t        r_wr_ptr;
  ptr_t        r_rd_ptr;
  cnt_t        r_count;
  logic        r_half_flag;
  logic [15:0] r_half_reg;
  logic        r_done;
  logic        r_open_q;
  logic        r_ready_core;
  logic [31:0] r_data;

  logic        w_open;
  logic        w_full;
  logic        w_empty;
  logic        w_accept;
  logic        w_wr_en;
  logic        w_pop;
  logic        w_open_rise;
  logic        w_done_next;
  logic [31:0] w_wr_word;
  cnt_t        w_count_next;

  assign w_open      = bus.user_r_read_32_open;
  assign w_full      = (r_count == CNT_FULL);
  assign w_empty     = (r_count == '0);
  assign w_open_rise = w_open & ~r_open_q;

  // Ready is gated combinationally by open so closing stops intake at once;
  // the full/done part is registered, so a same-cycle pop never raises it.
  assign bus.src_ready = w_open & r_ready_core;

  assign w_accept  = bus.src_valid & bus.src_ready;
  assign w_wr_en   = w_accept & (r_half_flag | bus.src_last);
  assign w_wr_word = r_half_flag ? {bus.src_data, r_half_reg} : {16'h0000, bus.src_data};
  assign w_pop     = w_open & bus.user_r_read_32_rden & ~w_empty;

  // A newly accepted last sample wins over the open rising edge.
  assign w_done_next = (r_done & ~w_open_rise) | (w_accept & bus.src_last);

  always_comb begin
    w_count_next = r_count;
    if (!w_open) begin
      w_count_next = '0;
    end else begin
      case ({w_wr_en, w_pop})
        2'b10:   w_count_next = r_count + CNT_ONE;
        2'b01:   w_count_next = r_count - CNT_ONE;
        default: w_count_next = r_count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; the pointers and count alone decide
  // what is valid, which keeps the array mappable onto block RAM.
  always_ff @(posedge bus_clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= w_wr_word;
  end

  always_ff @(posedge bus_clk) begin
    if (bus_rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_half_flag  <= 1'b0;
      r_half_reg   <= '0;
      r_done       <= 1'b0;
      r_open_q     <= 1'b0;
      r_ready_core <= 1'b0;
      r_data       <= '0;
    end else begin
      r_open_q     <= w_open;
      r_count      <= w_count_next;
      r_done       <= w_done_next;
      r_ready_core <= (w_count_next != CNT_FULL) & ~w_done_next;
      if (!w_open) begin
        // Closing the device flushes buffered and half-packed data.
        r_wr_ptr    <= '0;
        r_rd_ptr    <= '0;
        r_half_flag <= 1'b0;
      end else begin
        if (w_wr_en) r_wr_ptr <= r_wr_ptr + PTR_ONE;
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PTR_ONE;
          r_data   <= r_mem[r_rd_ptr];
        end
        if (w_accept) begin
          r_half_flag <= ~r_half_flag & ~bus.src_last;
          if (!r_half_flag) r_half_reg <= bus.src_data;
        end
      end
    end
  end

  assign bus.user_r_read_32_data  = r_data;
  assign bus.user_r_read_32_empty = w_empty;
  assign bus.user_r_read_32_eof   = r_done & w_empty & ~r_half_flag;

`ifdef XB_READ32_LEVEL_EN
  assign fifo_level = r_count;
`endif

endmodule
